// File: rtl/bf_program_loader.sv
// bf_program_loader: turns a stream of BF source bytes into 9-bit one-hot
// op codes, writes them into instruction memory from address 0 and appends
// HLT. Optional feature macro: BF_LOADER_CHECKSUM_EN adds an 8-bit checksum
// output summed over every instruction written, including HLT.
module bf_program_loader #(
  parameter int ADDR_W     = 16,
  parameter int IMEM_DEPTH = 65536,
  parameter int NEST_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [8:0]        imem_wdata,
  output logic              loader_select,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   prog_len
`ifdef BF_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [8:0] OP_NOP = 9'h000;
  localparam logic [8:0] OP_INC = 9'h001;
  localparam logic [8:0] OP_DEC = 9'h002;
  localparam logic [8:0] OP_MVR = 9'h004;
  localparam logic [8:0] OP_MVL = 9'h008;
  localparam logic [8:0] OP_PSH = 9'h010;
  localparam logic [8:0] OP_POP = 9'h020;
  localparam logic [8:0] OP_CBF = 9'h040;
  localparam logic [8:0] OP_CBB = 9'h080;
  localparam logic [8:0] OP_HLT = 9'h100;

  // The last slot is kept free so HLT always fits.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [NEST_W-1:0] DEPTH_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [NEST_W-1:0]   depth_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_addr_reg;
  logic [8:0]          imem_wdata_reg;
  logic                done_reg, error_reg;
  logic [ADDR_W:0]     prog_len_reg;
  logic [7:0]          checksum_reg;

  logic       is_cmd, is_term, is_open, is_close;
  logic [8:0] op;
  logic       accept, fault, do_write, do_term, start_load;
  logic [8:0] wr_data;
  logic [7:0] wr_sum_term;

  // Decode the incoming byte into its one-hot op and character class.
  always_comb begin
    op       = OP_NOP;
    is_cmd   = 1'b1;
    is_open  = 1'b0;
    is_close = 1'b0;
    is_term  = 1'b0;
    case (in_data)
      8'h2B: op = OP_INC;   // '+'
      8'h2D: op = OP_DEC;   // '-'
      8'h3E: op = OP_MVR;   // '>'
      8'h3C: op = OP_MVL;   // '<'
      8'h2E: op = OP_PSH;   // '.'
      8'h2C: op = OP_POP;   // ','
      8'h5B: begin op = OP_CBF; is_open  = 1'b1; end  // '['
      8'h5D: begin op = OP_CBB; is_close = 1'b1; end  // ']'
      8'h00: begin is_cmd = 1'b0; is_term = 1'b1; end
      default: is_cmd = 1'b0;  // comment byte
    endcase
  end

  assign accept     = in_valid && (state_reg == S_LOAD);
  assign fault      = accept && ((is_close && (depth_reg == '0)) ||
                                 (is_open && (depth_reg == DEPTH_MAX)) ||
                                 (is_cmd && (addr_reg == LAST_ADDR)) ||
                                 (is_term && (depth_reg != '0)));
  assign do_write   = accept && is_cmd && !fault;
  assign do_term    = accept && is_term && !fault;
  assign start_load = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                (state_reg == S_ERROR));
  assign wr_data     = do_term ? OP_HLT : op;
  assign wr_sum_term = wr_data[7:0] ^ {7'b0, wr_data[8]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LOAD;
      S_LOAD: begin
        if (fault)        state_next = S_ERROR;
        else if (do_term) state_next = S_TERM;
      end
      S_TERM:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Write port and counters: a write is registered at the accepting edge so
  // it appears on the memory port during the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= OP_NOP;
      addr_reg       <= '0;
      depth_reg      <= '0;
      prog_len_reg   <= '0;
      checksum_reg   <= '0;
    end else begin
      imem_we_reg <= 1'b0;
      if (start_load) begin
        addr_reg     <= '0;
        depth_reg    <= '0;
        prog_len_reg <= '0;
        checksum_reg <= '0;
      end
      if (do_write || do_term) begin
        imem_we_reg    <= 1'b1;
        imem_addr_reg  <= addr_reg;
        imem_wdata_reg <= wr_data;
        checksum_reg   <= checksum_reg + wr_sum_term;
      end
      if (do_write) begin
        addr_reg <= addr_reg + 1'b1;
        if (is_open)  depth_reg <= depth_reg + 1'b1;
        if (is_close) depth_reg <= depth_reg - 1'b1;
      end
      if (do_term) prog_len_reg <= {1'b0, addr_reg} + 1'b1;
    end
  end

  // Sticky completion flags, cleared when a new load begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      if (start_load) begin
        done_reg  <= 1'b0;
        error_reg <= 1'b0;
      end
      if (fault)                done_reg  <= 1'b0;
      if (fault)                error_reg <= 1'b1;
      if (state_reg == S_TERM)  done_reg  <= 1'b1;
    end
  end

  assign in_ready      = (state_reg == S_LOAD);
  assign loader_select = (state_reg == S_LOAD) || (state_reg == S_TERM);
  assign imem_we       = imem_we_reg;
  assign imem_addr     = imem_addr_reg;
  assign imem_wdata    = imem_wdata_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign prog_len      = prog_len_reg;
`ifdef BF_LOADER_CHECKSUM_EN
  assign checksum      = checksum_reg;
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: a reference model derived from the
// character rules predicts every memory write and the final outcome; a
// monitor compares each observed write against the predicted queue.
module tb_bf_program_loader;
  localparam int ADDR_W     = 16;
  localparam int IMEM_DEPTH = 16;
  localparam int NEST_W     = 2;
  localparam int MAX_NEST   = (1 << NEST_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, imem_we, loader_select, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [8:0]        imem_wdata;
  logic [ADDR_W:0]   prog_len;
`ifdef BF_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  bf_program_loader #(.ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH), .NEST_W(NEST_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .loader_select(loader_select), .done(done),
    .error(error), .prog_len(prog_len)
`ifdef BF_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  byte prog_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write the DUT presents must match the head
  // of the predicted queue.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%03h, none expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(imem_addr) !== e.addr || int'(imem_wdata) !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0d data=0x%03h expected addr=%0d data=0x%03h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end else begin
          $display("write addr=%0d data=0x%03h ok", imem_addr, imem_wdata);
        end
      end
    end
  end

  // Op code of a command character: bit position = index in this table.
  function automatic int op_of(input byte b);
    string cmds;
    cmds = "+-><.,[]";
    for (int i = 0; i < 8; i++) if (cmds[i] == b) return (1 << i);
    return 0;
  endfunction

  // Reference model: walk the source once, applying the loader's rules.
  int m_done, m_err, m_plen, m_nsend, m_cks;
  task automatic model();
    int depth, addr, op;
    depth = 0; addr = 0;
    m_done = 0; m_err = 0; m_plen = 0; m_nsend = prog_q.size(); m_cks = 0;
    for (int i = 0; i < prog_q.size(); i++) begin
      byte b;
      b = prog_q[i];
      op = op_of(b);
      if (b == 8'h00) begin
        m_nsend = i + 1;
        if (depth != 0) m_err = 1;
        else begin
          exp_q.push_back('{addr, 'h100});
          m_cks = (m_cks + 1) % 256;
          m_plen = addr + 1;
          m_done = 1;
        end
        return;
      end
      if (op != 0) begin
        if ((b == "]" && depth == 0) || (b == "[" && depth == MAX_NEST) ||
            addr == IMEM_DEPTH - 1) begin
          m_err = 1;
          m_nsend = i + 1;
          return;
        end
        exp_q.push_back('{addr, op});
        m_cks = (m_cks + op) % 256;
        addr++;
        if (b == "[") depth++;
        if (b == "]") depth--;
      end
    end
  endtask

  task automatic send_byte(input byte b);
    int w;
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w == 20) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_prog(input string name);
    int w;
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < m_nsend; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) @(negedge clk);
      send_byte(prog_q[i]);
    end
    w = 0;
    while (done !== 1'b1 && error !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w == 20) chk({name, "_finish_timeout"}, 0, 1);
    chk({name, "_done"}, int'(done), m_done);
    chk({name, "_error"}, int'(error), m_err);
    if (m_done != 0) chk({name, "_prog_len"}, int'(prog_len), m_plen);
`ifdef BF_LOADER_CHECKSUM_EN
    if (m_done != 0) chk({name, "_checksum"}, int'(checksum), m_cks);
`endif
    chk({name, "_loader_select"}, int'(loader_select), 0);
    chk({name, "_in_ready"}, int'(in_ready), 0);
    @(negedge clk);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
    $display("program %s: len=%0d done=%0d error=%0d prog_len=%0d",
             name, m_nsend, done, error, prog_len);
  endtask

  task automatic set_prog(input string s, input bit term);
    prog_q.delete();
    for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    if (term) prog_q.push_back(8'h00);
  endtask

  task automatic gen_random(input bit balanced);
    string cmds, cmts;
    int len, depth, r;
    byte b;
    cmds = "+-><.,[]";
    cmts = "ab \n";
    prog_q.delete();
    depth = 0;
    len = $urandom_range(0, 20);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = cmts[$urandom_range(0, 3)];
      else if (r < 4) b = (r == 2) ? "[" : "]";
      else if (!balanced && r == 9 && $urandom_range(0, 3) == 0) b = 8'h00;
      else b = cmds[$urandom_range(0, 7)];
      if (balanced && b == "]" && depth == 0) b = "+";
      if (balanced && b == "[" && depth == MAX_NEST) b = "-";
      if (b == "[") depth++;
      if (b == "]" && depth > 0) depth--;
      prog_q.push_back(b);
    end
    if (balanced) for (int i = 0; i < depth; i++) prog_q.push_back("]");
    prog_q.push_back(8'h00);
  endtask

  initial begin
    string s;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_imem_we", int'(imem_we), 0);
    chk("reset_imem_addr", int'(imem_addr), 0);
    chk("reset_imem_wdata", int'(imem_wdata), 0);
    chk("reset_loader_select", int'(loader_select), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_prog_len", int'(prog_len), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    set_prog("+-><.,[]", 1); run_prog("all_ops");
    set_prog("a+ b\n+", 1);  run_prog("comments");
    set_prog("]", 0);        run_prog("close_at_zero");
    set_prog("[[+]", 1);     run_prog("unbalanced_term");
    set_prog("[[[[", 1);     run_prog("nest_overflow");
    set_prog("", 1);         run_prog("empty");
    s = "";
    for (int i = 0; i < IMEM_DEPTH - 1; i++) s = {s, "+"};
    set_prog(s, 1);          run_prog("fill_to_last");
    set_prog({s, "+"}, 1);   run_prog("overflow_addr");

    // Reset in the middle of a load returns everything to reset values.
    set_prog("++", 0);
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte("+");
    send_byte("+");
    repeat (2) @(negedge clk);
    chk("midload_writes_seen", exp_q.size(), 0);
    #2 reset = 1'b1;
    #1;
    chk("midload_rst_in_ready", int'(in_ready), 0);
    chk("midload_rst_imem_we", int'(imem_we), 0);
    chk("midload_rst_imem_addr", int'(imem_addr), 0);
    chk("midload_rst_loader_select", int'(loader_select), 0);
    chk("midload_rst_done", int'(done), 0);
    chk("midload_rst_error", int'(error), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    set_prog("+", 1);        run_prog("after_reset");

    for (int t = 0; t < 40; t++) begin
      gen_random(t % 2 == 0);
      run_prog($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
